// File: rtl/regfile_alu_core.sv
// regfile_alu_core: register file plus two-stage ALU execution core.
//
// One operation is accepted per handshake (op_valid & op_ready). Source operands are read from
// the register file at the accept edge, the ALU result is computed during EXEC, and at the end
// of WB the result, flags and optional writeback commit together with a one-cycle done pulse.
// A direct load port writes the register bank in any state; a same-address writeback wins.
//
// Ports:
//   Clk, Reset                  clock, asynchronous active-high reset
//   Write_Reg, Addr, Data       direct register load
//   op_valid, op_ready          operation handshake
//   ALU_OP                      operation code (sampled on accept)
//   R_Addr_A, R_Addr_B          source registers (sampled on accept)
//   W_Addr, Write_Back          destination register and writeback enable (sampled on accept)
//   F, ZF, OF, CF               registered result and flags
//   done                        one-cycle pulse when F and flags update
//
// Build option: define ALU_SHIFT_EN to make ALU_OP 111 a logical left shift (A << B);
// otherwise ALU_OP 111 passes B through.

module regfile_alu_core #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Write_Reg,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [WIDTH-1:0]  Data,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        ALU_OP,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic              Write_Back,
    output logic [WIDTH-1:0]  F,
    output logic              ZF,
    output logic              OF,
    output logic              CF,
    output logic              done
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam int unsigned ShW     = $clog2(WIDTH);
    localparam int unsigned Msb     = WIDTH - 1;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWb
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]  rf_q [NumRegs];
    logic [WIDTH-1:0]  rf_d [NumRegs];

    // Operation context captured at accept
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              wb_en_q, wb_en_d;

    // ALU result staged at the end of EXEC, committed at the end of WB
    logic [WIDTH-1:0]  res_q, res_d;
    logic              of_res_q, of_res_d;
    logic              cf_res_q, cf_res_d;

    // Architectural outputs
    logic [WIDTH-1:0]  f_q, f_d;
    logic              zf_q, zf_d;
    logic              of_q, of_d;
    logic              cf_q, cf_d;
    logic              done_q, done_d;

    logic              wb_commit;

    // ------------------------------------------------------------------------------------------
    // ALU (combinational, works on the latched operands)
    // ------------------------------------------------------------------------------------------
    logic [WIDTH:0]    add_w;
    logic [WIDTH:0]    sub_w;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_of;
    logic              alu_cf;

    always_comb begin
        add_w   = {1'b0, a_q} + {1'b0, b_q};
        // Top bit of the widened difference is the unsigned borrow
        sub_w   = {1'b0, a_q} - {1'b0, b_q};
        alu_res = '0;
        alu_of  = 1'b0;
        alu_cf  = 1'b0;
        unique case (op_q)
            3'b000: alu_res = a_q & b_q;
            3'b001: alu_res = a_q | b_q;
            3'b010: begin
                alu_res = add_w[WIDTH-1:0];
                alu_cf  = add_w[WIDTH];
                alu_of  = (a_q[Msb] == b_q[Msb]) && (add_w[Msb] != a_q[Msb]);
            end
            3'b011: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_cf  = sub_w[WIDTH];
                alu_of  = (a_q[Msb] != b_q[Msb]) && (sub_w[Msb] != a_q[Msb]);
            end
            3'b100: alu_res = a_q ^ b_q;
            3'b101: alu_res = ~(a_q | b_q);
            3'b110: alu_res = {{(WIDTH - 1){1'b0}}, ($signed(a_q) < $signed(b_q))};
`ifdef ALU_SHIFT_EN
            3'b111: alu_res = a_q << b_q[ShW-1:0];
`else
            3'b111: alu_res = b_q;
`endif
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------------------------------
    // Control FSM and datapath next-state
    // ------------------------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        waddr_d   = waddr_q;
        wb_en_d   = wb_en_q;
        res_d     = res_q;
        of_res_d  = of_res_q;
        cf_res_d  = cf_res_q;
        f_d       = f_q;
        zf_d      = zf_q;
        of_d      = of_q;
        cf_d      = cf_q;
        done_d    = 1'b0;
        wb_commit = 1'b0;
        op_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    // Reads see pre-edge contents; a same-cycle load is not forwarded
                    a_d     = rf_q[R_Addr_A];
                    b_d     = rf_q[R_Addr_B];
                    op_d    = ALU_OP;
                    waddr_d = W_Addr;
                    wb_en_d = Write_Back;
                    state_d = StExec;
                end
            end
            StExec: begin
                res_d    = alu_res;
                of_res_d = alu_of;
                cf_res_d = alu_cf;
                state_d  = StWb;
            end
            StWb: begin
                f_d       = res_q;
                zf_d      = (res_q == '0);
                of_d      = of_res_q;
                cf_d      = cf_res_q;
                done_d    = 1'b1;
                wb_commit = wb_en_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Register file next-state: writeback is applied after the load so it wins on a collision
    always_comb begin
        for (int unsigned i = 0; i < NumRegs; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (Write_Reg) begin
            rf_d[Addr] = Data;
        end
        if (wb_commit) begin
            rf_d[waddr_q] = res_q;
        end
        rf_d[0] = '0;
    end

    // ------------------------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            waddr_q  <= '0;
            wb_en_q  <= 1'b0;
            res_q    <= '0;
            of_res_q <= 1'b0;
            cf_res_q <= 1'b0;
            f_q      <= '0;
            zf_q     <= 1'b0;
            of_q     <= 1'b0;
            cf_q     <= 1'b0;
            done_q   <= 1'b0;
            for (int unsigned i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            waddr_q  <= waddr_d;
            wb_en_q  <= wb_en_d;
            res_q    <= res_d;
            of_res_q <= of_res_d;
            cf_res_q <= cf_res_d;
            f_q      <= f_d;
            zf_q     <= zf_d;
            of_q     <= of_d;
            cf_q     <= cf_d;
            done_q   <= done_d;
            for (int unsigned i = 0; i < NumRegs; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign F    = f_q;
    assign ZF   = zf_q;
    assign OF   = of_q;
    assign CF   = cf_q;
    assign done = done_q;

endmodule

// File: tb/tb_regfile_alu_core.sv
// Directed self-checking bench for regfile_alu_core (WIDTH=32, ADDR_W=5).
module tb_regfile_alu_core;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Write_Reg;
    logic [4:0]  Addr;
    logic [31:0] Data;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  ALU_OP;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [4:0]  W_Addr;
    logic        Write_Back;
    logic [31:0] F;
    logic        ZF, OF, CF;
    logic        done;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] OpAnd = 3'b000, OpOr = 3'b001, OpAdd = 3'b010, OpSub = 3'b011;
    localparam logic [2:0] OpXor = 3'b100, OpNor = 3'b101, OpSlt = 3'b110, OpX = 3'b111;

    regfile_alu_core #(.WIDTH(32), .ADDR_W(5)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Write_Reg  (Write_Reg),
        .Addr       (Addr),
        .Data       (Data),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .ALU_OP     (ALU_OP),
        .R_Addr_A   (R_Addr_A),
        .R_Addr_B   (R_Addr_B),
        .W_Addr     (W_Addr),
        .Write_Back (Write_Back),
        .F          (F),
        .ZF         (ZF),
        .OF         (OF),
        .CF         (CF),
        .done       (done)
    );

    always #5 Clk = ~Clk;

    task automatic do_reset();
        Reset = 1'b1;
        Write_Reg = 0; Addr = 0; Data = 0; op_valid = 0; ALU_OP = 0;
        R_Addr_A = 0; R_Addr_B = 0; W_Addr = 0; Write_Back = 0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        @(negedge Clk);
        Write_Reg = 1'b1; Addr = a; Data = d;
        @(posedge Clk); #1;
        Write_Reg = 1'b0;
    endtask

    // Issues one operation and waits for done; lat is accept-to-done edge count (0 on timeout).
    task automatic run_op(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] wa, input logic wb, output int lat);
        int n;
        lat = 0;
        @(negedge Clk);
        ALU_OP = op; R_Addr_A = ra; R_Addr_B = rb; W_Addr = wa; Write_Back = wb;
        op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (op_ready) begin
            @(posedge Clk); #1;
            op_valid = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                @(posedge Clk); #1;
                if (done) begin
                    lat = k;
                    break;
                end
            end
        end
        op_valid = 1'b0;
        if (lat == 0) begin
            tests++;
            fails++;
            $display("FAIL op_timeout: got no done, expected done within bound");
        end
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        int lat;
        run_op(OpOr, r, 5'd0, 5'd0, 1'b0, lat);
        v = F;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Write_Reg = 0; Addr = 0; Data = 0; op_valid = 0; ALU_OP = 0;
        R_Addr_A = 0; R_Addr_B = 0; W_Addr = 0; Write_Back = 0;
        #3;
        tests++;
        if (F !== 32'd0) begin fails++; $display("FAIL reset_F: got %h, expected 0", F); end
        tests++;
        if ({ZF, OF, CF, done} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags: got %b, expected 0000", {ZF, OF, CF, done});
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        tests++;
        if (op_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b, expected 1", op_ready);
        end
    endtask

    task automatic test_add_basic();
        int lat;
        logic [31:0] v;
        load(5'd1, 32'd5);
        load(5'd2, 32'd3);
        run_op(OpAdd, 5'd1, 5'd2, 5'd3, 1'b1, lat);
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL add_latency: got %0d, expected 2", lat); end
        tests++;
        if ({F, ZF, OF, CF} !== {32'd8, 3'b000}) begin
            fails++; $display("FAIL add_basic: got %h/%b%b%b, expected 8/000", F, ZF, OF, CF);
        end
        read_reg(5'd3, v);
        tests++;
        if (v !== 32'd8) begin fails++; $display("FAIL add_wb_r3: got %h, expected 8", v); end
        run_op(OpOr, 5'd0, 5'd0, 5'd0, 1'b0, lat);
        tests++;
        if ({F, ZF} !== {32'd0, 1'b1}) begin
            fails++; $display("FAIL zero_flag: got %h/%b, expected 0/1", F, ZF);
        end
    endtask

    task automatic test_arith_flags();
        int lat;
        load(5'd1, 32'h7FFF_FFFF);
        load(5'd2, 32'd1);
        run_op(OpAdd, 5'd1, 5'd2, 5'd0, 1'b0, lat);
        tests++;
        if ({F, OF, CF} !== {32'h8000_0000, 2'b10}) begin
            fails++; $display("FAIL add_ovf: got %h/%b%b, expected 80000000/10", F, OF, CF);
        end
        load(5'd1, 32'hFFFF_FFFF);
        run_op(OpAdd, 5'd1, 5'd2, 5'd0, 1'b0, lat);
        tests++;
        if ({F, ZF, OF, CF} !== {32'd0, 3'b101}) begin
            fails++; $display("FAIL add_carry: got %h/%b%b%b, expected 0/101", F, ZF, OF, CF);
        end
        load(5'd1, 32'd2);
        run_op(OpSub, 5'd2, 5'd1, 5'd0, 1'b0, lat);
        tests++;
        if ({F, ZF, OF, CF} !== {32'hFFFF_FFFF, 3'b001}) begin
            fails++; $display("FAIL sub_borrow: got %h/%b%b%b, expected ffffffff/001", F, ZF, OF, CF);
        end
        load(5'd1, 32'h8000_0000);
        run_op(OpSub, 5'd1, 5'd2, 5'd0, 1'b0, lat);
        tests++;
        if ({F, OF, CF} !== {32'h7FFF_FFFF, 2'b10}) begin
            fails++; $display("FAIL sub_ovf: got %h/%b%b, expected 7fffffff/10", F, OF, CF);
        end
    endtask

    task automatic test_logic_ops();
        int lat;
        logic [2:0]  ops [4] = '{OpAnd, OpOr, OpXor, OpNor};
        logic [31:0] exp [4] = '{32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'hFFFF_000F};
        load(5'd8, 32'h0000_F0F0);
        load(5'd9, 32'h0000_FF00);
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 5'd8, 5'd9, 5'd0, 1'b0, lat);
            tests++;
            if ({F, OF, CF} !== {exp[i], 2'b00}) begin
                fails++; $display("FAIL logic_op%0d: got %h/%b%b, expected %h/00", i, F, OF, CF, exp[i]);
            end
        end
    endtask

    task automatic test_slt_and_op7();
        int lat;
        logic [31:0] exp7;
`ifdef ALU_SHIFT_EN
        exp7 = 32'd16;
`else
        exp7 = 32'd4;
`endif
        load(5'd10, 32'hFFFF_FFFF);
        run_op(OpSlt, 5'd10, 5'd0, 5'd0, 1'b0, lat);
        tests++;
        if (F !== 32'd1) begin fails++; $display("FAIL slt_neg: got %h, expected 1", F); end
        run_op(OpSlt, 5'd0, 5'd10, 5'd0, 1'b0, lat);
        tests++;
        if ({F, ZF} !== {32'd0, 1'b1}) begin
            fails++; $display("FAIL slt_pos: got %h/%b, expected 0/1", F, ZF);
        end
        // Leave CF set beforehand so op 111 must actively clear it
        run_op(OpSub, 5'd0, 5'd10, 5'd0, 1'b0, lat);
        load(5'd11, 32'd1);
        load(5'd12, 32'd4);
        run_op(OpX, 5'd11, 5'd12, 5'd0, 1'b0, lat);
        tests++;
        if ({F, OF, CF} !== {exp7, 2'b00}) begin
            fails++; $display("FAIL op7: got %h/%b%b, expected %h/00", F, OF, CF, exp7);
        end
    endtask

    task automatic test_wb_conflicts();
        int lat;
        logic [31:0] v;
        load(5'd1, 32'd5);
        load(5'd2, 32'd3);
        run_op(OpAdd, 5'd1, 5'd2, 5'd0, 1'b1, lat);
        read_reg(5'd0, v);
        tests++;
        if (v !== 32'd0) begin fails++; $display("FAIL r0_write: got %h, expected 0", v); end
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge Clk);
            ALU_OP = OpAdd; R_Addr_A = 5'd1; R_Addr_B = 5'd2; W_Addr = 5'd4; Write_Back = 1'b1;
            op_valid = 1'b1;
            @(posedge Clk); #1;
            op_valid = 1'b0;
            @(posedge Clk);
            @(negedge Clk);
            Write_Reg = 1'b1; Addr = (pass == 0) ? 5'd4 : 5'd5; Data = (pass == 0) ? 32'd9 : 32'd77;
            @(posedge Clk); #1;
            Write_Reg = 1'b0;
            tests++;
            if (done !== 1'b1) begin fails++; $display("FAIL wb_done%0d: got %b, expected 1", pass, done); end
        end
        read_reg(5'd4, v);
        tests++;
        if (v !== 32'd8) begin fails++; $display("FAIL wb_wins_r4: got %h, expected 8", v); end
        read_reg(5'd5, v);
        tests++;
        if (v !== 32'd77) begin fails++; $display("FAIL load_r5: got %h, expected 77", v); end
        // Load on the accept edge is not forwarded to the operand read
        @(negedge Clk);
        ALU_OP = OpAdd; R_Addr_A = 5'd1; R_Addr_B = 5'd2; W_Addr = 5'd0; Write_Back = 1'b0;
        op_valid = 1'b1; Write_Reg = 1'b1; Addr = 5'd1; Data = 32'd100;
        @(posedge Clk); #1;
        op_valid = 1'b0; Write_Reg = 1'b0;
        tests++;
        if (op_ready !== 1'b0) begin fails++; $display("FAIL ready_low: got %b, expected 0", op_ready); end
        repeat (2) @(posedge Clk);
        #1;
        tests++;
        if (F !== 32'd8) begin fails++; $display("FAIL no_forward: got %h, expected 8", F); end
        read_reg(5'd1, v);
        tests++;
        if (v !== 32'd100) begin fails++; $display("FAIL load_r1: got %h, expected 100", v); end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int busy = 0;
        logic [31:0] v;
        do_reset();
        load(5'd1, 32'd1);
        @(negedge Clk);
        ALU_OP = OpAdd; R_Addr_A = 5'd6; R_Addr_B = 5'd1; W_Addr = 5'd6; Write_Back = 1'b1;
        op_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge Clk); #1;
            if (done) dones++;
            if (!op_ready) busy++;
        end
        op_valid = 1'b0;
        tests++;
        if (dones !== 3) begin fails++; $display("FAIL b2b_dones: got %0d, expected 3", dones); end
        tests++;
        if (busy !== 6) begin fails++; $display("FAIL b2b_busy: got %0d, expected 6", busy); end
        read_reg(5'd6, v);
        tests++;
        if (v !== 32'd3) begin fails++; $display("FAIL b2b_r6: got %h, expected 3", v); end
    endtask

    task automatic test_reset_exec();
        int lat;
        logic [31:0] v;
        run_op(OpSub, 5'd0, 5'd1, 5'd0, 1'b0, lat);
        @(negedge Clk);
        ALU_OP = OpAdd; R_Addr_A = 5'd6; R_Addr_B = 5'd1; W_Addr = 5'd7; Write_Back = 1'b1;
        op_valid = 1'b1;
        @(posedge Clk); #1;
        op_valid = 1'b0;
        #2 Reset = 1'b1;
        #1;
        tests++;
        if ({F, ZF, OF, CF, done} !== 36'd0) begin
            fails++; $display("FAIL rst_exec_out: got %h/%b%b%b%b, expected 0/0000", F, ZF, OF, CF, done);
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        tests++;
        if (op_ready !== 1'b1) begin fails++; $display("FAIL rst_exec_ready: got %b, expected 1", op_ready); end
        repeat (3) @(posedge Clk);
        #1;
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL rst_exec_nodone: got %b, expected 0", done); end
        read_reg(5'd7, v);
        tests++;
        if (v !== 32'd0) begin fails++; $display("FAIL rst_exec_r7: got %h, expected 0", v); end
        read_reg(5'd6, v);
        tests++;
        if (v !== 32'd0) begin fails++; $display("FAIL rst_exec_r6: got %h, expected 0", v); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_arith_flags();
        test_logic_ops();
        test_slt_and_op7();
        test_wb_conflicts();
        test_back_to_back();
        test_reset_exec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_alu_core.md
# regfile_alu_core

Parametrised register-file-plus-ALU execution core, the next generation of the lab datapath that pairs the register bank with the ALU. It accepts one operation per handshake, reads two source registers, computes the result over a two-stage sequence, and writes the result back into the register file while holding registered flags. A direct load port still allows the register bank to be preloaded from outside.

## Interface
- WIDTH, 32, datapath and register width in bits (≥ 8)
- ADDR_W, 5, register address width; register count is 2^ADDR_W
- Clk  in  1  rising-edge clock; single clock domain
- Reset  in  1  asynchronous, active-high reset
- Write_Reg  in  1  direct load enable
- Addr  in  ADDR_W  direct load address
- Data  in  WIDTH  direct load data
- op_valid  in  1  operation request
- op_ready  out  1  core can accept an operation
- ALU_OP  in  3  operation code, sampled on accept
- R_Addr_A, R_Addr_B  in  ADDR_W  source register addresses, sampled on accept
- W_Addr  in  ADDR_W  destination register, sampled on accept
- Write_Back  in  1  write the result to W_Addr when 1, sampled on accept
- F  out  WIDTH  last result, registered
- ZF, OF, CF  out  1 each  zero, signed-overflow and carry/borrow flags, registered
- done  out  1  one-cycle pulse when the result and flags update

## Operation
- Register 0 always reads as 0. Writes to register 0 are discarded.
- States:
  - IDLE: op_ready=1. Moves to EXEC on op_valid & op_ready.
  - EXEC: operands A/B were latched from the register file at the accept edge; the ALU computes.
  - WB: F and flags register; writeback happens when enabled; done=1; returns to IDLE.
- ALU_OP encoding:
  - 000 AND, 001 OR, 010 ADD, 011 SUB (A−B), 100 XOR, 101 NOR
  - 110 SLT: signed A<B gives 1, else 0
  - 111: see Configuration
- Flags:
  - ZF = (F==0).
  - ADD: OF = signed overflow; CF = carry out of the MSB.
  - SUB: OF = signed overflow; CF = borrow (1 when A<B unsigned).
  - All other ops: OF=CF=0.
- Direct load is accepted in every state and writes Data to Addr at the clock edge.
- A load and a writeback in the same cycle to different addresses both complete. If they target the same address, the writeback wins and the load is dropped.
- Operand reads at the accept edge see register contents from before that edge. A load in the same cycle is not forwarded.
- Arithmetic wraps modulo 2^WIDTH.

## Timing
- Accept at edge N. EXEC during cycle N+1. F, flags, writeback and done all update at edge N+2.
- done is high for exactly one cycle. op_ready is low from edge N until edge N+2, so one operation completes every 3 cycles at best.
- op_valid without op_ready is ignored. Requesters hold op_valid until they see a handshake.
- Reset (asynchronous, any state):
  - state goes to IDLE
  - all registers clear to 0
  - F=0, ZF=0, OF=0, CF=0, done=0; op_ready=1 once Reset deasserts
  - an in-flight operation is abandoned with no writeback
- Outputs hold their values between operations.

## Configuration
- ALU_SHIFT_EN defined: ALU_OP 111 is a logical left shift, F = A << B[log2(WIDTH)-1:0].
- ALU_SHIFT_EN undefined: ALU_OP 111 passes B through, F = B.
- In both cases op 111 forces OF=CF=0. No other behaviour changes.

## Test plan
- Reset, then load r1=5 and r2=3; accept ADD(r1,r2), W_Addr=3 -> done at accept+2, F=8, ZF=0, OF=0, CF=0, r3=8.
- WIDTH=32, r1=0x7FFFFFFF, r2=1, ADD -> F=0x80000000, OF=1, CF=0. Then SUB r2−r1 with r1=2, r2=1 -> F=0xFFFFFFFF, CF=1, OF=0.
- Write_Back=1 with W_Addr=0 -> read of r0 returns 0. Load 9 to r4 while WB also targets r4 with result 8 -> r4=8. Load to r5 in the same cycle -> r5 updated.
- op_valid held high continuously -> op_ready low for 2 cycles per operation, one done per 3 cycles, no operation lost or duplicated.
- Reset asserted during EXEC -> next cycle F=0, flags 0, destination register 0, op_ready=1 after release.
- op 111 with A=1, B=4 -> F=16 with ALU_SHIFT_EN defined, F=4 without it. SLT with A=−1, B=0 -> F=1.
